phi2_sequencer: RTL and testbench

- Sits directly downstream of the clock scaler.
- Converts the scaler's divided square wave into the 6502 bus-cycle clocks (phi1/phi2), with single-cycle edge strobes for bus devices.
- Stretches phi2-high by a programmable number of scaled periods for slow devices.
- Provides run/single-step control and a free-running bus-cycle counter.
- Everything runs in the input_clock domain; scaled_clock is a registered signal from the same domain.

---
 rtl/phi2_sequencer.sv | 143 ++++++++++++++
 tb/tb_phi2_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/phi2_sequencer.sv
// 6502 bus-cycle clock generator: turns the scaler's divided clock into phi1/phi2
// with edge strobes, slow-device stretching, run/single-step control and a cycle counter.
module phi2_sequencer #(
  parameter int WAIT_WIDTH  = 3,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   input_clock,
  input  logic                   reset,
  input  logic                   scaled_clock,
  input  logic                   run,
  input  logic                   step,
  input  logic                   slow_access,
  input  logic [WAIT_WIDTH-1:0]  wait_states,
  output logic                   phi2,
  output logic                   phi1,
  output logic                   phi2_rise,
  output logic                   phi2_fall,
  output logic                   stretching,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] cycle_count
);

  typedef enum logic [1:0] {PHI1, PHI2, STRETCH} state_t;

  state_t                 state_reg, state_next;
  logic [WAIT_WIDTH-1:0]  wait_reg, wait_next;
  logic                   pending_reg, pending_next;
  logic                   scaled_q;
  logic                   phi2_reg, phi2_next;
  logic                   phi1_reg, phi1_next;
  logic                   rise_reg, rise_next;
  logic                   fall_reg, fall_next;
  logic                   stretch_reg, stretch_next;
  logic                   halted_reg, halted_next;
  logic [COUNT_WIDTH-1:0] count_reg, count_next;

  logic rise;
  logic fall;
  logic go;
  logic start;

  assign rise  = scaled_clock & ~scaled_q;
  assign fall  = ~scaled_clock & scaled_q;
  assign go    = run | pending_reg | step;
  assign start = (state_reg == PHI1) & rise & go;

  always_ff @(posedge input_clock) begin
    if (reset) begin
      state_reg   <= PHI1;
      wait_reg    <= '0;
      pending_reg <= 1'b0;
      scaled_q    <= 1'b0;
      phi2_reg    <= 1'b0;
      phi1_reg    <= 1'b1;
      rise_reg    <= 1'b0;
      fall_reg    <= 1'b0;
      stretch_reg <= 1'b0;
      halted_reg  <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      wait_reg    <= wait_next;
      pending_reg <= pending_next;
      scaled_q    <= scaled_clock;
      phi2_reg    <= phi2_next;
      phi1_reg    <= phi1_next;
      rise_reg    <= rise_next;
      fall_reg    <= fall_next;
      stretch_reg <= stretch_next;
      halted_reg  <= halted_next;
      count_reg   <= count_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    wait_next    = wait_reg;
    pending_next = pending_reg;
    phi2_next    = phi2_reg;
    rise_next    = 1'b0;
    fall_next    = 1'b0;
    stretch_next = stretch_reg;
    count_next   = count_reg;

    case (state_reg)
      PHI1: begin
        if (start) begin
          state_next   = PHI2;
          phi2_next    = 1'b1;
          rise_next    = 1'b1;
          wait_next    = slow_access ? wait_states : '0;
          pending_next = 1'b0;
        end
      end
      PHI2: begin
        if (fall) begin
          if (wait_reg == '0) begin
            state_next = PHI1;
            phi2_next  = 1'b0;
            fall_next  = 1'b1;
            count_next = count_reg + 1'b1;
          end else begin
            state_next   = STRETCH;
            stretch_next = 1'b1;
          end
        end
      end
      STRETCH: begin
        if (fall) begin
          wait_next = wait_reg - 1'b1;
          if (wait_reg == WAIT_WIDTH'(1)) begin
            state_next   = PHI1;
            phi2_next    = 1'b0;
            fall_next    = 1'b1;
            stretch_next = 1'b0;
            count_next   = count_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next   = PHI1;
        phi2_next    = 1'b0;
        stretch_next = 1'b0;
      end
    endcase

    // A step that is not consumed by this very rise is remembered (no queueing)
    if (step & ~run & ~start)
      pending_next = 1'b1;

    phi1_next   = ~phi2_next;
    halted_next = (state_next == PHI1) & ~run & ~pending_next;
  end

  assign phi2        = phi2_reg;
  assign phi1        = phi1_reg;
  assign phi2_rise   = rise_reg;
  assign phi2_fall   = fall_reg;
  assign stretching  = stretch_reg;
  assign halted      = halted_reg;
  assign cycle_count = count_reg;

endmodule

// File: tb/tb_phi2_sequencer.sv
// Bench for phi2_sequencer: vector table of bus cycles plus hand-written halt, step,
// wrap and reset-in-stretch sequences; bus-cycle shapes are checked through a scoreboard queue.
module tb_phi2_sequencer;

  localparam int WW = 3;
  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic          scaled;
  logic          run;
  logic          step;
  logic          slow;
  logic [WW-1:0] ws;
  logic          phi2;
  logic          phi1;
  logic          phi2_rise;
  logic          phi2_fall;
  logic          stretching;
  logic          halted;
  logic [CW-1:0] cycle_count;

  phi2_sequencer #(.WAIT_WIDTH(WW), .COUNT_WIDTH(CW)) dut (
    .input_clock (clk),
    .reset       (reset),
    .scaled_clock(scaled),
    .run         (run),
    .step        (step),
    .slow_access (slow),
    .wait_states (ws),
    .phi2        (phi2),
    .phi1        (phi1),
    .phi2_rise   (phi2_rise),
    .phi2_fall   (phi2_fall),
    .stretching  (stretching),
    .halted      (halted),
    .cycle_count (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int high;
    int str;
  } exp_t;

  typedef struct {
    logic          run;
    logic          slow;
    logic [WW-1:0] ws;
    logic          cycle;
    int            high;
    int            str;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[8];

  int errors    = 0;
  int checks    = 0;
  int exp_count = 0;
  int rise_cnt  = 0;
  int high_len  = 0;
  int str_len   = 0;
  bit mon_en    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic half(input logic lvl, input int n);
    scaled = lvl;
    repeat (n) tick();
  endtask

  task automatic period();
    half(1'b1, 4);
    half(1'b0, 4);
  endtask

  task automatic expect_cycle(input int high, input int str);
    exp_t e;
    e.high = high;
    e.str  = str;
    exp_q.push_back(e);
  endtask

  // Per-cycle monitor: invariants plus measurement of each completed bus cycle
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      check("phi1_inv", phi1, !phi2);
      check("strobe_excl", phi2_rise & phi2_fall, 0);
      if (phi2_rise) begin
        high_len = 1;
        str_len  = 0;
        rise_cnt++;
      end else if (phi2) begin
        high_len++;
      end
      if (stretching) str_len++;
      if (phi2_fall) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cycle", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("high_len", high_len, e.high);
          check("stretch_len", str_len, e.str);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    int n;

    vecs[0] = '{run: 1'b1, slow: 1'b0, ws: 3'd0, cycle: 1'b1, high: 4,  str: 0};
    vecs[1] = '{run: 1'b1, slow: 1'b0, ws: 3'd5, cycle: 1'b1, high: 4,  str: 0};
    vecs[2] = '{run: 1'b1, slow: 1'b1, ws: 3'd0, cycle: 1'b1, high: 4,  str: 0};
    vecs[3] = '{run: 1'b1, slow: 1'b1, ws: 3'd2, cycle: 1'b1, high: 20, str: 16};
    vecs[4] = '{run: 1'b1, slow: 1'b0, ws: 3'd0, cycle: 1'b1, high: 4,  str: 0};
    vecs[5] = '{run: 1'b1, slow: 1'b1, ws: 3'd1, cycle: 1'b1, high: 12, str: 8};
    vecs[6] = '{run: 1'b1, slow: 1'b1, ws: 3'd7, cycle: 1'b1, high: 60, str: 56};
    vecs[7] = '{run: 1'b0, slow: 1'b1, ws: 3'd3, cycle: 1'b0, high: 0,  str: 0};

    reset = 1'b1; scaled = 1'b0; run = 1'b1; step = 1'b0; slow = 1'b0; ws = '0;
    repeat (3) tick();
    check("rst_phi2", phi2, 0);
    check("rst_phi1", phi1, 1);
    check("rst_rise", phi2_rise, 0);
    check("rst_fall", phi2_fall, 0);
    check("rst_stretching", stretching, 0);
    check("rst_count", cycle_count, 0);
    reset = 1'b0;
    mon_en = 1;
    tick();

    // Three plain periods with explicit one-cycle lag checks on the first
    repeat (3) expect_cycle(4, 0);
    half(1'b1, 1);
    check("lag_phi2_up", phi2, 1);
    check("lag_rise", phi2_rise, 1);
    tick();
    check("rise_one_cycle", phi2_rise, 0);
    repeat (2) tick();
    half(1'b0, 1);
    check("lag_phi2_down", phi2, 0);
    check("lag_fall", phi2_fall, 1);
    tick();
    check("fall_one_cycle", phi2_fall, 0);
    repeat (2) tick();
    period();
    period();
    exp_count = 3;
    check("count_3", cycle_count, 3);

    // Vector table: inputs at the rise, then scrambled to prove they are sampled only there
    for (int i = 0; i < 8; i++) begin
      run  = vecs[i].run;
      slow = vecs[i].slow;
      ws   = vecs[i].ws;
      rc   = rise_cnt;
      if (vecs[i].cycle) expect_cycle(vecs[i].high, vecs[i].str);
      n = (vecs[i].high + 4) / 8;
      if (n < 1) n = 1;
      half(1'b1, 1);
      slow = ~vecs[i].slow;
      ws   = ~vecs[i].ws;
      repeat (3) tick();
      half(1'b0, 4);
      repeat (n - 1) period();
      exp_count += int'(vecs[i].cycle);
      check($sformatf("vec%0d_count", i), cycle_count, exp_count % 16);
      check($sformatf("vec%0d_rises", i), rise_cnt - rc, int'(vecs[i].cycle));
      check($sformatf("vec%0d_halted", i), halted, !vecs[i].run);
      check($sformatf("vec%0d_phi2", i), phi2, 0);
    end

    // run dropped mid phi2-high of a stretched cycle: cycle completes, then halt
    run = 1'b1; slow = 1'b1; ws = 3'd1;
    expect_cycle(12, 8);
    half(1'b1, 1);
    run = 1'b0; slow = 1'b0; ws = '0;
    repeat (3) tick();
    half(1'b0, 4);
    period();
    exp_count++;
    check("halt_count", cycle_count, exp_count % 16);
    rc = rise_cnt;
    repeat (5) period();
    check("halt_no_rise", rise_cnt - rc, 0);
    check("halt_phi2", phi2, 0);
    check("halt_halted", halted, 1);
    check("halt_count_frozen", cycle_count, exp_count % 16);

    // Two step pulses before the next rise give exactly one bus cycle
    rc = rise_cnt;
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step_pending_unhalts", halted, 0);
    repeat (2) tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    expect_cycle(4, 0);
    repeat (3) period();
    exp_count++;
    check("step_one_cycle", rise_cnt - rc, 1);
    check("step_count", cycle_count, exp_count % 16);
    check("step_halted", halted, 1);

    // Counter wrap
    run = 1'b1;
    while ((exp_count % 16) != 15) begin
      expect_cycle(4, 0);
      period();
      exp_count++;
    end
    check("count_15", cycle_count, 15);
    expect_cycle(4, 0);
    period();
    exp_count++;
    check("count_wrap", cycle_count, 0);

    // Reset while stretching with three waits left
    run = 1'b1; slow = 1'b1; ws = 3'd3;
    half(1'b1, 4);
    slow = 1'b0; ws = '0;
    half(1'b0, 2);
    check("pre_rst_stretching", stretching, 1);
    half(1'b1, 2);
    check("pre_rst_phi2", phi2, 1);
    reset = 1'b1;
    tick();
    check("mid_rst_phi2", phi2, 0);
    check("mid_rst_phi1", phi1, 1);
    check("mid_rst_stretching", stretching, 0);
    check("mid_rst_fall", phi2_fall, 0);
    check("mid_rst_count", cycle_count, 0);
    reset = 1'b0;
    exp_count = 0;
    expect_cycle(4, 0);
    tick();
    check("post_rst_rise", phi2_rise, 1);
    check("post_rst_phi2", phi2, 1);
    repeat (3) tick();
    half(1'b0, 4);
    exp_count++;
    check("post_rst_count", cycle_count, exp_count % 16);

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
